// File: rtl/proc_mem_responder.sv
// proc_mem_responder
// Memory-side responder for a single-cycle core: one word-addressed RAM shared
// by the fetch and data ports, a side-band loader, and a 20-byte MMIO window
// (OUT0, OUT1, IN, CYCLE, STATUS). Reads are combinational; every state change
// lands on the rising clock edge.
module proc_mem_responder #(
  parameter int unsigned p_num_words = 256,
  parameter logic [31:0] p_io_base   = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  input  logic        dmem_val,
  input  logic        dmem_type,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  input  logic [31:0] io_in,
  output logic [31:0] io_out0,
  output logic [31:0] io_out1,
  output logic        io_err
);

  localparam int unsigned aw        = $clog2(p_num_words);
  localparam logic [31:0] ram_bytes = 32'(4 * p_num_words);
  localparam logic [31:0] io_end    = p_io_base + 32'd20;

  // Word select inside the I/O window; the window is 32-byte aligned, so the
  // low address bits are the offset directly.
  localparam logic [2:0] sel_out0   = 3'd0;
  localparam logic [2:0] sel_out1   = 3'd1;
  localparam logic [2:0] sel_in     = 3'd2;
  localparam logic [2:0] sel_cycle  = 3'd3;
  localparam logic [2:0] sel_status = 3'd4;

  logic [31:0] mem_q [p_num_words];

  logic [31:0] out0_q, out0_d;
  logic [31:0] out1_q, out1_d;
  logic [31:0] in_q;
  logic [31:0] cycle_q, cycle_d;
  logic        err_q, err_d;

  logic          d_ram_hit, d_io_hit, d_misal, d_ro_store;
  logic          d_bad, d_ok, d_store, d_load, clr_err;
  logic [2:0]    io_sel;
  logic [31:0]   io_rdata;
  logic          i_ram_hit, l_ram_hit;
  logic [aw-1:0] d_idx, i_idx, l_idx;
  logic          ram_we, ld_we;

  // Byte-offset bits play no part in RAM indexing for fetch and loader.
  logic unused_low_bits;
  assign unused_low_bits = ^{imem_addr[1:0], ld_addr[1:0]};

  assign d_idx = dmem_addr[aw+1:2];
  assign i_idx = imem_addr[aw+1:2];
  assign l_idx = ld_addr[aw+1:2];

  // Classify the data-port access: legal, or an error that writes nothing.
  always_comb begin
    d_ram_hit  = (dmem_addr < ram_bytes);
    d_io_hit   = (dmem_addr >= p_io_base) && (dmem_addr < io_end);
    d_misal    = (dmem_addr[1:0] != 2'b00);
    io_sel     = dmem_addr[4:2];
    d_ro_store = dmem_type && d_io_hit &&
                 ((io_sel == sel_in) || (io_sel == sel_cycle));
    d_bad      = dmem_val && (d_misal || (!d_ram_hit && !d_io_hit) || d_ro_store);
    d_ok       = dmem_val && !d_bad;
    d_store    = d_ok && dmem_type;
    d_load     = d_ok && !dmem_type;
    clr_err    = d_store && d_io_hit && (io_sel == sel_status) && dmem_wdata[0];
    i_ram_hit  = (imem_addr < ram_bytes);
    l_ram_hit  = (ld_addr < ram_bytes);
    ram_we     = d_store && d_ram_hit;
    ld_we      = ld_en && l_ram_hit;
  end

  // RAM write port; the loader write is issued last so it wins a same-word tie.
  // Contents survive reset, but no write is taken while reset is high.
  always_ff @(posedge clk) begin
    if (!rst && ram_we) mem_q[d_idx] <= dmem_wdata;
    if (!rst && ld_we)  mem_q[l_idx] <= ld_wdata;
  end

  // Next-state for the MMIO registers and the sticky error flag.
  always_comb begin
    out0_d  = out0_q;
    out1_d  = out1_q;
    cycle_d = cycle_q + 32'd1;
    err_d   = err_q;
    if (d_store && d_io_hit && (io_sel == sel_out0)) out0_d = dmem_wdata;
    if (d_store && d_io_hit && (io_sel == sel_out1)) out1_d = dmem_wdata;
    if (d_bad)   err_d = 1'b1;
    // A clear can only come from a legal store, so it takes priority.
    if (clr_err) err_d = 1'b0;
  end

  // MMIO register state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out0_q  <= '0;
      out1_q  <= '0;
      in_q    <= '0;
      cycle_q <= '0;
      err_q   <= 1'b0;
    end else begin
      out0_q  <= out0_d;
      out1_q  <= out1_d;
      in_q    <= io_in;
      cycle_q <= cycle_d;
      err_q   <= err_d;
    end
  end

  // Combinational read paths for both ports.
  always_comb begin
    case (io_sel)
      sel_out0:   io_rdata = out0_q;
      sel_out1:   io_rdata = out1_q;
      sel_in:     io_rdata = in_q;
      sel_cycle:  io_rdata = cycle_q;
      sel_status: io_rdata = {31'b0, err_q};
      default:    io_rdata = '0;
    endcase
    dmem_rdata = '0;
    if (d_load) dmem_rdata = d_ram_hit ? mem_q[d_idx] : io_rdata;
    imem_rdata = i_ram_hit ? mem_q[i_idx] : '0;
  end

  assign io_out0 = out0_q;
  assign io_out1 = out1_q;
  assign io_err  = err_q;

endmodule

// File: tb/tb_proc_mem_responder.sv
// Self-checking bench for proc_mem_responder against a behavioural model of
// the memory map (RAM array, MMIO registers, sticky error flag).
module tb_proc_mem_responder;

  localparam int          N    = 256;
  localparam logic [31:0] IOB  = 32'h0000_2000;
  localparam logic [31:0] RAMB = 32'(4 * N);

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_val, dmem_type;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        ld_en;
  logic [31:0] ld_addr, ld_wdata;
  logic [31:0] io_in, io_out0, io_out1;
  logic        io_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_mem [N];
  logic [31:0] m_out0 = 0, m_out1 = 0, m_in = 0, m_cyc = 0;
  logic        m_err = 0;

  proc_mem_responder #(.p_num_words(N), .p_io_base(IOB)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_val(dmem_val), .dmem_type(dmem_type), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .io_in(io_in), .io_out0(io_out0), .io_out1(io_out1), .io_err(io_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int widx(input logic [31:0] a);
    return int'(a >> 2);
  endfunction

  // 0 = RAM, 1..5 = OUT0/OUT1/IN/CYCLE/STATUS, -1 = unmapped
  function automatic int m_kind(input logic [31:0] a);
    if (a < RAMB) return 0;
    if (a >= IOB && a < IOB + 32'd20) return 1 + int'((a - IOB) >> 2);
    return -1;
  endfunction

  function automatic logic m_illegal(input logic v, input logic t, input logic [31:0] a);
    int k;
    k = m_kind(a);
    return v && ((a % 4) != 0 || k < 0 || (t && (k == 3 || k == 4)));
  endfunction

  function automatic logic [31:0] m_load(input logic v, input logic t, input logic [31:0] a);
    if (!v || t || m_illegal(v, t, a)) return 32'h0;
    case (m_kind(a))
      0: return m_mem[widx(a)];
      1: return m_out0;
      2: return m_out1;
      3: return m_in;
      4: return m_cyc;
      5: return {31'b0, m_err};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_fetch(input logic [31:0] a);
    return (a < RAMB) ? m_mem[widx(a)] : 32'h0;
  endfunction

  // One clock with the currently driven inputs; ends on the following negedge.
  task automatic tick();
    logic bad, clr;
    int   k;
    bad = m_illegal(dmem_val, dmem_type, dmem_addr);
    k   = m_kind(dmem_addr);
    clr = 1'b0;
    @(posedge clk);
    if (dmem_val && dmem_type && !bad) begin
      case (k)
        0: m_mem[widx(dmem_addr)] = dmem_wdata;
        1: m_out0 = dmem_wdata;
        2: m_out1 = dmem_wdata;
        5: clr = dmem_wdata[0];
        default: ;
      endcase
    end
    if (ld_en && ld_addr < RAMB) m_mem[widx(ld_addr)] = ld_wdata;
    if (bad) m_err = 1'b1;
    if (clr) m_err = 1'b0;
    m_in  = io_in;
    m_cyc = m_cyc + 32'd1;
    @(negedge clk);
  endtask

  task automatic set_idle();
    dmem_val = 0; dmem_type = 0; dmem_addr = 0; dmem_wdata = 0;
    ld_en = 0; ld_addr = 0; ld_wdata = 0; imem_addr = 0;
  endtask

  task automatic drive_d(input logic t, input logic [31:0] a, input logic [31:0] wd);
    dmem_val = 1; dmem_type = t; dmem_addr = a; dmem_wdata = wd;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 6))
      0, 1: return 32'($urandom_range(0, N - 1)) << 2;
      2:    return IOB + (32'($urandom_range(0, 4)) << 2);
      3:    return IOB + 32'($urandom_range(0, 19));
      4: begin
        case ($urandom_range(0, 4))
          0: return RAMB - 32'd4;
          1: return RAMB;
          2: return IOB - 32'd4;
          3: return IOB + 32'd20;
          default: return 32'h0000_3000;
        endcase
      end
      5:    return 32'($urandom_range(0, 4 * N - 1));
      default: return $urandom();
    endcase
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; set_idle(); io_in = 32'h1234_5678;
    @(negedge clk);
    drive_d(0, IOB + 32'hC, 0);
    #1;
    n_checks++; if (io_out0 !== 32'h0) begin n_errors++; $display("FAIL reset_out0: got %h want 0", io_out0); end
    n_checks++; if (io_out1 !== 32'h0) begin n_errors++; $display("FAIL reset_out1: got %h want 0", io_out1); end
    n_checks++; if (io_err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b want 0", io_err); end
    n_checks++; if (dmem_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_cycle: got %h want 0", dmem_rdata); end
    @(posedge clk); @(negedge clk);
    drive_d(0, IOB + 32'h8, 0);
    #1;
    n_checks++; if (dmem_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_in: got %h want 0", dmem_rdata); end
    rst = 0;
    m_out0 = 0; m_out1 = 0; m_in = 0; m_cyc = 0; m_err = 0;
    set_idle();
  endtask

  task automatic fill_mem();
    for (int i = 0; i < N; i++) begin
      set_idle();
      ld_en = 1; ld_addr = 32'(i) << 2; ld_wdata = $urandom();
      tick();
    end
    set_idle();
  endtask

  task automatic test_load_fetch();
    set_idle(); ld_en = 1; ld_addr = 32'h10; ld_wdata = 32'hDEAD_BEEF; tick();
    set_idle(); ld_en = 1; ld_addr = 32'h14; ld_wdata = 32'h1234_5678; tick();
    set_idle(); imem_addr = 32'h10; drive_d(0, 32'h14, 0);
    #1;
    n_checks++; if (imem_rdata !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL fetch_10: got %h want DEADBEEF", imem_rdata); end
    n_checks++; if (dmem_rdata !== 32'h1234_5678) begin n_errors++; $display("FAIL load_14: got %h want 12345678", dmem_rdata); end
    imem_addr = 32'h13;
    #1;
    n_checks++; if (imem_rdata !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL fetch_low_bits: got %h want DEADBEEF", imem_rdata); end
    imem_addr = RAMB;
    #1;
    n_checks++; if (imem_rdata !== 32'h0) begin n_errors++; $display("FAIL fetch_unmapped: got %h want 0", imem_rdata); end
    tick();
    n_checks++; if (io_err !== 1'b0) begin n_errors++; $display("FAIL load_fetch_err: got %b want 0", io_err); end
  endtask

  task automatic test_forwarding();
    logic [31:0] old;
    old = m_mem[8];
    set_idle(); drive_d(1, 32'h20, 32'hA5A5_A5A5); imem_addr = 32'h20;
    #1;
    n_checks++; if (imem_rdata !== old) begin n_errors++; $display("FAIL fwd_old: got %h want %h", imem_rdata, old); end
    tick();
    set_idle(); drive_d(0, 32'h20, 0); imem_addr = 32'h20;
    #1;
    n_checks++; if (dmem_rdata !== 32'hA5A5_A5A5) begin n_errors++; $display("FAIL fwd_new: got %h want A5A5A5A5", dmem_rdata); end
    n_checks++; if (imem_rdata !== 32'hA5A5_A5A5) begin n_errors++; $display("FAIL fwd_new_fetch: got %h want A5A5A5A5", imem_rdata); end
    // loader write racing a load of the same word
    old = m_mem[9];
    set_idle(); drive_d(0, 32'h24, 0); ld_en = 1; ld_addr = 32'h24; ld_wdata = 32'h0BAD_F00D;
    #1;
    n_checks++; if (dmem_rdata !== old) begin n_errors++; $display("FAIL ld_race_old: got %h want %h", dmem_rdata, old); end
    tick();
    // loader and store to the same word: loader wins
    set_idle(); drive_d(1, 32'h28, 32'h1111_1111); ld_en = 1; ld_addr = 32'h28; ld_wdata = 32'h2222_2222;
    tick();
    set_idle(); drive_d(0, 32'h28, 0);
    #1;
    n_checks++; if (dmem_rdata !== 32'h2222_2222) begin n_errors++; $display("FAIL ld_wins: got %h want 22222222", dmem_rdata); end
    tick();
  endtask

  task automatic test_mmio();
    logic [31:0] v;
    set_idle(); drive_d(1, IOB, 32'h0000_00FF); tick();
    n_checks++; if (io_out0 !== 32'hFF) begin n_errors++; $display("FAIL out0_wr: got %h want FF", io_out0); end
    set_idle(); drive_d(0, IOB, 0);
    #1;
    n_checks++; if (dmem_rdata !== 32'hFF) begin n_errors++; $display("FAIL out0_rd: got %h want FF", dmem_rdata); end
    tick();
    v = $urandom();
    set_idle(); drive_d(1, IOB + 32'h4, v); tick();
    n_checks++; if (io_out1 !== v) begin n_errors++; $display("FAIL out1_wr: got %h want %h", io_out1, v); end
    set_idle(); io_in = 32'h55; drive_d(0, IOB + 32'h8, 0);
    #1;
    n_checks++; if (dmem_rdata !== m_in) begin n_errors++; $display("FAIL in_latency: got %h want %h", dmem_rdata, m_in); end
    tick();
    set_idle(); io_in = 32'h66; drive_d(0, IOB + 32'h8, 0);
    #1;
    n_checks++; if (dmem_rdata !== 32'h55) begin n_errors++; $display("FAIL in_rd: got %h want 55", dmem_rdata); end
    tick();
    set_idle(); drive_d(0, IOB + 32'hC, 0);
    #1;
    n_checks++; if (dmem_rdata !== m_cyc) begin n_errors++; $display("FAIL cycle_rd: got %h want %h", dmem_rdata, m_cyc); end
    tick();
  endtask

  task automatic test_errors();
    logic [31:0] old;
    set_idle(); drive_d(0, 32'h0000_0402, 0);
    #1;
    n_checks++; if (dmem_rdata !== 32'h0) begin n_errors++; $display("FAIL misal_rdata: got %h want 0", dmem_rdata); end
    tick();
    n_checks++; if (io_err !== 1'b1) begin n_errors++; $display("FAIL misal_err: got %b want 1", io_err); end
    set_idle(); drive_d(1, IOB + 32'hC, 32'h0); tick();
    n_checks++; if (io_err !== 1'b1) begin n_errors++; $display("FAIL ro_store_err: got %b want 1", io_err); end
    set_idle(); drive_d(0, IOB + 32'hC, 0);
    #1;
    n_checks++; if (dmem_rdata !== m_cyc) begin n_errors++; $display("FAIL ro_store_cycle: got %h want %h", dmem_rdata, m_cyc); end
    tick();
    set_idle(); drive_d(0, IOB + 32'h10, 0);
    #1;
    n_checks++; if (dmem_rdata !== 32'h1) begin n_errors++; $display("FAIL status_rd: got %h want 1", dmem_rdata); end
    tick();
    set_idle(); drive_d(1, IOB + 32'h10, 32'hFFFF_FFFE); tick();
    n_checks++; if (io_err !== 1'b1) begin n_errors++; $display("FAIL status_w0: got %b want 1", io_err); end
    set_idle(); drive_d(1, IOB + 32'h10, 32'h1); tick();
    n_checks++; if (io_err !== 1'b0) begin n_errors++; $display("FAIL status_clr: got %b want 0", io_err); end
    set_idle(); drive_d(0, 32'h0000_3000, 0); tick();
    n_checks++; if (io_err !== 1'b1) begin n_errors++; $display("FAIL unmapped_err: got %b want 1", io_err); end
    old = m_mem[16];
    set_idle(); drive_d(1, 32'h41, 32'hCAFE_0001); tick();
    set_idle(); drive_d(0, 32'h40, 0);
    #1;
    n_checks++; if (dmem_rdata !== old) begin n_errors++; $display("FAIL misal_store_dropped: got %h want %h", dmem_rdata, old); end
    tick();
    set_idle(); drive_d(1, IOB + 32'h10, 32'h1); tick();
    n_checks++; if (io_err !== 1'b0) begin n_errors++; $display("FAIL status_clr2: got %b want 0", io_err); end
  endtask

  task automatic test_random();
    logic [31:0] exp_r, exp_i;
    for (int i = 0; i < 400; i++) begin
      set_idle();
      dmem_val   = ($urandom_range(0, 3) != 0);
      dmem_type  = 1'($urandom_range(0, 1));
      dmem_addr  = rand_addr();
      dmem_wdata = $urandom();
      ld_en      = ($urandom_range(0, 4) == 0);
      ld_addr    = ($urandom_range(0, 1) != 0) ? dmem_addr : rand_addr();
      ld_wdata   = $urandom();
      imem_addr  = rand_addr();
      io_in      = $urandom();
      #1;
      exp_r = m_load(dmem_val, dmem_type, dmem_addr);
      exp_i = m_fetch(imem_addr);
      n_checks++; if (dmem_rdata !== exp_r) begin n_errors++; $display("FAIL rnd_dmem[%0d] addr %h: got %h want %h", i, dmem_addr, dmem_rdata, exp_r); end
      n_checks++; if (imem_rdata !== exp_i) begin n_errors++; $display("FAIL rnd_imem[%0d] addr %h: got %h want %h", i, imem_addr, imem_rdata, exp_i); end
      tick();
      n_checks++; if (io_out0 !== m_out0) begin n_errors++; $display("FAIL rnd_out0[%0d]: got %h want %h", i, io_out0, m_out0); end
      n_checks++; if (io_out1 !== m_out1) begin n_errors++; $display("FAIL rnd_out1[%0d]: got %h want %h", i, io_out1, m_out1); end
      n_checks++; if (io_err !== m_err) begin n_errors++; $display("FAIL rnd_err[%0d]: got %b want %b", i, io_err, m_err); end
    end
    set_idle();
  endtask

  task automatic test_counter_wrap();
    set_idle();
    force dut.cycle_q = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_q;
    m_cyc = 32'hFFFF_FFFE;
    drive_d(0, IOB + 32'hC, 0);
    #1;
    n_checks++; if (dmem_rdata !== 32'hFFFF_FFFE) begin n_errors++; $display("FAIL wrap_fffe: got %h want FFFFFFFE", dmem_rdata); end
    tick();
    #1;
    n_checks++; if (dmem_rdata !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL wrap_ffff: got %h want FFFFFFFF", dmem_rdata); end
    tick();
    #1;
    n_checks++; if (dmem_rdata !== 32'h0) begin n_errors++; $display("FAIL wrap_zero: got %h want 0", dmem_rdata); end
    tick();
    set_idle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] keep;
    keep = m_mem[8];
    set_idle(); drive_d(1, IOB + 32'h4, 32'h7); tick();
    set_idle(); drive_d(0, 32'h0000_3000, 0); tick();
    n_checks++; if (io_out1 !== 32'h7 || io_err !== 1'b1) begin n_errors++; $display("FAIL rstmid_setup: got out1 %h err %b want 7 1", io_out1, io_err); end
    set_idle(); drive_d(1, IOB, 32'h0000_0099);
    #2; rst = 1; #1;
    n_checks++; if (io_out0 !== 32'h0) begin n_errors++; $display("FAIL rstmid_out0: got %h want 0", io_out0); end
    n_checks++; if (io_out1 !== 32'h0) begin n_errors++; $display("FAIL rstmid_out1: got %h want 0", io_out1); end
    n_checks++; if (io_err !== 1'b0) begin n_errors++; $display("FAIL rstmid_err: got %b want 0", io_err); end
    @(posedge clk); @(negedge clk);
    m_out0 = 0; m_out1 = 0; m_in = 0; m_cyc = 0; m_err = 0;
    n_checks++; if (io_out0 !== 32'h0) begin n_errors++; $display("FAIL rstmid_store_dropped: got %h want 0", io_out0); end
    rst = 0;
    set_idle(); drive_d(0, IOB + 32'hC, 0); imem_addr = 32'h20;
    #1;
    n_checks++; if (dmem_rdata !== 32'h0) begin n_errors++; $display("FAIL rstmid_cycle0: got %h want 0", dmem_rdata); end
    n_checks++; if (imem_rdata !== keep) begin n_errors++; $display("FAIL rstmid_ram_kept: got %h want %h", imem_rdata, keep); end
    tick();
    #1;
    n_checks++; if (dmem_rdata !== 32'h1) begin n_errors++; $display("FAIL rstmid_cycle1: got %h want 1", dmem_rdata); end
    n_checks++; if (io_out0 !== 32'h0) begin n_errors++; $display("FAIL rstmid_out0_after: got %h want 0", io_out0); end
    tick();
    set_idle();
  endtask

  initial begin
    rst = 1; io_in = 0; set_idle();
    test_reset();
    fill_mem();
    test_load_fetch();
    test_forwarding();
    test_mmio();
    test_errors();
    test_random();
    test_counter_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/proc_mem_responder.md
# proc_mem_responder

Responder side of the single-cycle processor's memory interfaces. It services the instruction fetch port and the data load/store port from one shared word-addressed RAM, plus a small memory-mapped I/O window: two output registers, a sampled input register, a free-running cycle counter and a sticky error/status register. Reads are combinational, so the processor completes a load or fetch in its own cycle. Writes commit on the rising clock edge. A side-band loader port fills the RAM before the program runs.

## Interface

- p_num_words, default 256: RAM depth in 32-bit words; power of two, 16..4096.
- p_io_base, default 32'h0000_2000: base byte address of the I/O window; must lie above RAM (≥ 4*p_num_words), 32-byte aligned.

Ports:

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- imem_addr  in  32  fetch byte address.
- imem_rdata  out  32  fetched word.
- dmem_val  in  1  data access valid this cycle.
- dmem_type  in  1  0 = load, 1 = store.
- dmem_addr  in  32  data byte address.
- dmem_wdata  in  32  store data.
- dmem_rdata  out  32  load data.
- ld_en  in  1  loader write enable.
- ld_addr  in  32  loader byte address (RAM only).
- ld_wdata  in  32  loader data.
- io_in  in  32  external input value.
- io_out0  out  32  output register 0.
- io_out1  out  32  output register 1.
- io_err  out  1  sticky access-error flag.

## Operation

- RAM index: addr[log2(p_num_words)+1:2]. RAM hit when addr < 4*p_num_words. I/O hit when p_io_base ≤ addr < p_io_base+20.
- I/O map, by offset from p_io_base:
  - +0x00 OUT0, read/write.
  - +0x04 OUT1, read/write.
  - +0x08 IN, read-only. Returns in_reg, which samples io_in every edge.
  - +0x0C CYCLE, read-only. 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF → 0.
  - +0x10 STATUS, read returns {31'b0, err}. A store with wdata[0]=1 clears err (write-1-to-clear).
- imem_rdata: RAM word if imem_addr is a RAM hit, else 0. Fetch never sets err. Low address bits [1:0] are ignored on fetch.
- dmem_rdata: if dmem_val && !dmem_type, the selected RAM/I-O value; otherwise 0.
- err is set at the edge for any dmem_val access that is:
  - misaligned (dmem_addr[1:0] ≠ 0);
  - unmapped (neither RAM hit nor I/O hit);
  - a store to IN or CYCLE.
  
  Such accesses write nothing, and loads among them return 0.
- Set vs clear conflict: a store to STATUS clearing err wins over any set in the same cycle. Such a store is itself legal and cannot also raise an error.
- Loader: ld_en writes ld_wdata to RAM[ld_addr index]. Ignored (no err) if ld_addr is not a RAM hit. If ld_en and a dmem store target the same RAM word in the same cycle, the loader wins.
- RAM contents are not reset.

## Timing

- Reads: zero latency, purely combinational from current state. A load in the same cycle as a store to the same address returns the old value; the new value is visible the next cycle.
- Stores, loader writes, err update and counter increment: all take effect at the rising edge.
- IN latency: io_in change at cycle N is readable at cycle N+1.
- CYCLE read in cycle k after reset deassertion returns k (first cycle returns 0).
- Reset (async, any time):
  - io_out0 = 0, io_out1 = 0, io_err = 0, in_reg = 0, CYCLE = 0, immediately on assertion.
  - A store or loader write coinciding with the asserting edge is dropped.
  - RAM keeps its contents.
  - Counting resumes on the first edge after deassertion.

## Test plan

- Load-then-fetch: loader writes 0xDEAD_BEEF to byte 0x10 and 0x1234_5678 to 0x14.
  - imem_addr=0x10 returns 0xDEAD_BEEF.
  - dmem load from 0x14 returns 0x1234_5678.
  - io_err stays 0.
- Store/load forwarding boundary: store 0xA5A5_A5A5 to 0x20 while loading 0x20 in the same cycle.
  - That cycle's dmem_rdata = old value.
  - Next cycle's load = 0xA5A5_A5A5.
- MMIO:
  - Store 0x0000_00FF to p_io_base → io_out0 = 0xFF after the edge; reading back returns 0xFF.
  - Drive io_in = 0x55 → IN read the next cycle returns 0x55.
- Errors:
  - Load from 0x0000_0402 (misaligned) → rdata 0, io_err = 1 after the edge.
  - Store to p_io_base+0x0C → io_err stays 1 and CYCLE is unaffected.
  - Store 1 to STATUS → io_err = 0.
  - Load from 0x0000_3000 (unmapped) → io_err = 1.
- Counter wrap: reach CYCLE = 0xFFFF_FFFE via long run or force.
  - Reads over the next two cycles are 0xFFFF_FFFF, then 0.
- Reset mid-operation: assert rst asynchronously mid-cycle, with io_out1 = 7, err = 1 and a store pending to OUT0.
  - All outputs go 0 immediately; the pending store is not applied.
  - RAM word previously written still reads back unchanged after reset.
